// File: rtl/uio_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uio_arb_pkg
// Brief   : Shared types and constants for the uio pad-bus arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package uio_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_TURN = 2'd1,
        ARB_XFER = 2'd2
    } arb_state_t;

    localparam int               UIO_W      = 8;
    localparam logic [UIO_W-1:0] OE_DRIVE   = 8'hFF;
    localparam logic [UIO_W-1:0] OE_RELEASE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/uio_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin search: first set req at or after ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int               w_j;
        logic [PTR_W-1:0] w_pos;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        w_j    = 0;
        w_pos  = '0;
        // Walk NREQ positions starting at ptr, wrapping at NREQ
        for (int k = 0; k < NREQ; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            w_pos = PTR_W'(w_j);
            if (!valid && req[w_pos]) begin
                valid         = 1'b1;
                onehot[w_pos] = 1'b1;
                idx           = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uio_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uio_port_arbiter
// Brief   : Round-robin sharing of the bidirectional uio pads with turnaround.
// Revision: 1.0 - initial release
// ============================================================================
module uio_port_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int MAX_BEATS   = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       dir_out,
    input  logic [UIO_W*NREQ-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [UIO_W-1:0]      rdata,
    output logic                  rvalid,
    input  logic [UIO_W-1:0]      uio_in,
    output logic [UIO_W-1:0]      uio_out,
    output logic [UIO_W-1:0]      uio_oe
);

    localparam int c_PTR_W  = $clog2(NREQ);
    localparam int c_BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int c_TURN_W = $clog2(TURN_CYCLES + 1);

    arb_state_t          r_state;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [c_PTR_W-1:0]  r_owner;
    logic                r_bus_dir;
    logic [c_BEAT_W-1:0] r_beat_cnt;
    logic [c_TURN_W-1:0] r_turn_cnt;

    logic [NREQ-1:0]     w_onehot;
    logic [c_PTR_W-1:0]  w_idx;
    logic                w_any;
    logic                w_beat;
    logic                w_last;
    logic [NREQ-1:0]     w_owner_1h;
    logic [c_PTR_W-1:0]  w_next_ptr;
    logic [UIO_W-1:0]    w_wdata_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_wdata
        assign w_wdata_arr[g] = wdata[UIO_W*g +: UIO_W];
    end

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (c_PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_onehot),
        .idx    (w_idx),
        .valid  (w_any)
    );

    assign w_beat     = gnt[r_owner] & req[r_owner] & ena;
    assign w_last     = (r_beat_cnt == c_BEAT_W'(MAX_BEATS - 1));
    assign w_owner_1h = NREQ'(1) << r_owner;
    assign w_next_ptr = (r_owner == c_PTR_W'(NREQ - 1)) ? '0 : r_owner + c_PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_bus_dir  <= 1'b0;
            r_beat_cnt <= '0;
            r_turn_cnt <= '0;
            gnt        <= '0;
            uio_out    <= '0;
            uio_oe     <= OE_RELEASE;
            rdata      <= '0;
            rvalid     <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (ena && w_any) begin
                        r_owner <= w_idx;
                        if (dir_out[w_idx] != r_bus_dir) begin
                            // Release the pads before the new direction takes over
                            r_state    <= ARB_TURN;
                            r_bus_dir  <= dir_out[w_idx];
                            uio_oe     <= OE_RELEASE;
                            r_turn_cnt <= '0;
                        end else begin
                            r_state <= ARB_XFER;
                            gnt     <= w_onehot;
                        end
                    end
                end
                ARB_TURN: begin
                    if (!ena) begin
                        // Abort forgets the pending direction so a later out grant turns again
                        r_state    <= ARB_IDLE;
                        r_bus_dir  <= 1'b0;
                        r_turn_cnt <= '0;
                    end else if (r_turn_cnt == c_TURN_W'(TURN_CYCLES - 1)) begin
                        r_state    <= ARB_XFER;
                        gnt        <= w_owner_1h;
                        r_turn_cnt <= '0;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + c_TURN_W'(1);
                    end
                end
                ARB_XFER: begin
                    if (w_beat) begin
                        if (r_bus_dir) begin
                            uio_out <= w_wdata_arr[r_owner];
                            uio_oe  <= OE_DRIVE;
                        end else begin
                            rdata  <= uio_in;
                            rvalid <= 1'b1;
                        end
                        r_beat_cnt <= r_beat_cnt + c_BEAT_W'(1);
                    end
                    if (!w_beat || w_last) begin
                        r_state    <= ARB_IDLE;
                        gnt        <= '0;
                        r_ptr      <= w_next_ptr;
                        r_beat_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uio_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uio_port_arbiter
// Brief   : Directed, table-driven and randomized checks of uio_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uio_port_arbiter;

    localparam int B_N    = 3;
    localparam int B_MAX  = 2;
    localparam int B_TURN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        ena;
    logic [1:0]  req, dir_out, gnt;
    logic [15:0] wdata;
    logic [7:0]  rdata, uio_in, uio_out, uio_oe;
    logic        rvalid;

    logic           b_ena;
    logic [B_N-1:0] b_req, b_dir, b_gnt;
    logic [8*B_N-1:0] b_wdata;
    logic [7:0]     b_rdata, b_uio_in, b_uio_out, b_uio_oe;
    logic           b_rvalid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uio_port_arbiter #(.NREQ(2), .MAX_BEATS(4), .TURN_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .dir_out(dir_out),
        .wdata(wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    uio_port_arbiter #(.NREQ(B_N), .MAX_BEATS(B_MAX), .TURN_CYCLES(B_TURN)) dut_b (
        .clk(clk), .rst(rst), .ena(b_ena), .req(b_req), .dir_out(b_dir),
        .wdata(b_wdata), .gnt(b_gnt), .rdata(b_rdata), .rvalid(b_rvalid),
        .uio_in(b_uio_in), .uio_out(b_uio_out), .uio_oe(b_uio_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b0; req = '0; dir_out = '0; wdata = '0; uio_in = '0;
        b_ena = 1'b0; b_req = '0; b_dir = '0; b_wdata = '0; b_uio_in = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model of the arbiter rules for the second instance
    int          m_phase;      // 0 idle, 1 turnaround, 2 transfer
    int          m_owner, m_left, m_beats, m_ptr;
    bit          m_busdir, m_rvalid;
    logic [B_N-1:0] m_gnt;
    logic [7:0]  m_out, m_oe, m_rdata;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_left = 0; m_beats = 0; m_ptr = 0;
        m_busdir = 0; m_rvalid = 0; m_gnt = '0; m_out = '0; m_oe = '0; m_rdata = '0;
    endtask

    task automatic model_edge();
        bit beat;
        m_rvalid = 0;
        if (m_phase == 0) begin
            if (b_ena && b_req != '0) begin
                for (int k = B_N - 1; k >= 0; k--) begin
                    if (b_req[(m_ptr + k) % B_N]) m_owner = (m_ptr + k) % B_N;
                end
                if (b_dir[m_owner] != m_busdir) begin
                    m_phase = 1; m_left = B_TURN; m_busdir = b_dir[m_owner]; m_oe = 8'h00;
                end else begin
                    m_phase = 2; m_gnt = B_N'(1) << m_owner;
                end
            end
        end else if (m_phase == 1) begin
            if (!b_ena) begin
                m_phase = 0; m_busdir = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 2; m_gnt = B_N'(1) << m_owner;
                end
            end
        end else begin
            beat = b_req[m_owner] && b_ena;
            if (beat) begin
                if (m_busdir) begin
                    m_out = b_wdata[8*m_owner +: 8]; m_oe = 8'hFF;
                end else begin
                    m_rdata = b_uio_in; m_rvalid = 1;
                end
                m_beats++;
            end
            if (!beat || m_beats == B_MAX) begin
                m_phase = 0; m_gnt = '0; m_ptr = (m_owner + 1) % B_N; m_beats = 0;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  dir;
        logic [15:0] wdata;
        logic [1:0]  gnt;
        logic [7:0]  oe;
        logic [7:0]  out;
        logic        rv;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rv_cnt, upd, phase;
        logic [1:0] expg;
        logic [7:0] prev;

        tbl[0] = '{2'b01, 2'b01, 16'h00A5, 2'b00, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{2'b01, 2'b01, 16'h00A5, 2'b01, 8'h00, 8'h00, 1'b0};
        tbl[2] = '{2'b01, 2'b01, 16'h00A5, 2'b01, 8'hFF, 8'hA5, 1'b0};
        tbl[3] = '{2'b01, 2'b01, 16'h00A5, 2'b01, 8'hFF, 8'hA5, 1'b0};
        tbl[4] = '{2'b01, 2'b01, 16'h00A5, 2'b01, 8'hFF, 8'hA5, 1'b0};
        tbl[5] = '{2'b01, 2'b01, 16'h00A5, 2'b00, 8'hFF, 8'hA5, 1'b0};
        tbl[6] = '{2'b00, 2'b01, 16'h00A5, 2'b00, 8'hFF, 8'hA5, 1'b0};
        tbl[7] = '{2'b00, 2'b00, 16'h0000, 2'b00, 8'hFF, 8'hA5, 1'b0};

        // Reset values and single out burst with turnaround
        do_reset();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_oe", 32'(uio_oe), 0);
        check("rst_out", 32'(uio_out), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", 32'(rdata), 0);
        ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req; dir_out = tbl[i].dir; wdata = tbl[i].wdata;
            step();
            check($sformatf("t1_gnt[%0d]", i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("t1_oe[%0d]", i), 32'(uio_oe), 32'(tbl[i].oe));
            check($sformatf("t1_out[%0d]", i), 32'(uio_out), 32'(tbl[i].out));
            check($sformatf("t1_rv[%0d]", i), 32'(rvalid), 32'(tbl[i].rv));
        end

        // Two in-requesters alternate with one idle cycle between grants
        do_reset();
        ena = 1'b1; req = 2'b11; dir_out = 2'b00; uio_in = 8'h3C;
        rv_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            phase = (k - 1) % 5;
            expg = (phase == 4) ? 2'b00 : ((k <= 5) ? 2'b01 : 2'b10);
            check($sformatf("t2_gnt[%0d]", k), 32'(gnt), 32'(expg));
            check($sformatf("t2_rv[%0d]", k), 32'(rvalid), 32'(phase != 0));
            check($sformatf("t2_oe[%0d]", k), 32'(uio_oe), 0);
            if (rvalid) begin
                rv_cnt++;
                check("t2_rdata", 32'(rdata), 32'h3C);
            end
        end
        check("t2_rv_count", 32'(rv_cnt), 8);

        // Out burst, then in burst with turnaround
        do_reset();
        ena = 1'b1; req = 2'b11; dir_out = 2'b01; wdata = 16'h005A;
        for (int k = 1; k <= 12; k++) begin
            uio_in = 8'(8'h40 + k);
            step();
            if (k == 1) check("t3_turn1_gnt", 32'(gnt), 0);
            if (k == 6) check("t3_idle_oe", 32'(uio_oe), 32'hFF);
            if (k == 6) check("t3_idle_out", 32'(uio_out), 32'h5A);
            if (k == 7) check("t3_turn2_oe", 32'(uio_oe), 0);
            if (k == 7) check("t3_turn2_gnt", 32'(gnt), 0);
            if (k == 8) check("t3_gnt1", 32'(gnt), 32'b10);
            if (k == 8) check("t3_gnt1_oe", 32'(uio_oe), 0);
            if (k == 9) check("t3_first_rv", 32'(rvalid), 1);
            if (k == 9) check("t3_first_rdata", 32'(rdata), 32'h49);
        end

        // Early req drop after two beats
        do_reset();
        ena = 1'b1; req = 2'b01; dir_out = 2'b01;
        prev = 8'h00; upd = 0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 5) req = 2'b00;
            wdata = 16'(8'h10 + k);
            step();
            if (uio_out != prev) begin
                upd++;
                prev = uio_out;
            end
            if (k == 4) check("t4_gnt_held", 32'(gnt), 32'b01);
            if (k == 5) check("t4_gnt_drop", 32'(gnt), 0);
            if (k == 5) check("t4_last_out", 32'(uio_out), 32'h14);
            if (k == 7) check("t4_idle_oe", 32'(uio_oe), 32'hFF);
        end
        check("t4_updates", 32'(upd), 2);

        // ena low during turnaround
        do_reset();
        ena = 1'b1; req = 2'b01; dir_out = 2'b01; wdata = 16'h0033;
        step();
        check("t5_turn_gnt", 32'(gnt), 0);
        ena = 1'b0;
        step();
        check("t5_abort_gnt", 32'(gnt), 0);
        check("t5_abort_oe", 32'(uio_oe), 0);
        step();
        check("t5_off_gnt", 32'(gnt), 0);
        ena = 1'b1;
        step();
        check("t5_returned_gnt", 32'(gnt), 0);
        check("t5_returned_oe", 32'(uio_oe), 0);
        step();
        check("t5_grant", 32'(gnt), 32'b01);

        // Async reset in the second transfer cycle of a burst
        do_reset();
        ena = 1'b1; req = 2'b01; dir_out = 2'b01; wdata = 16'h0077;
        repeat (8) step();
        check("t6_pre_gnt", 32'(gnt), 32'b01);
        check("t6_pre_out", 32'(uio_out), 32'h77);
        #2;
        rst = 1'b1;
        #1;
        check("t6_gnt", 32'(gnt), 0);
        check("t6_oe", 32'(uio_oe), 0);
        check("t6_out", 32'(uio_out), 0);
        check("t6_rvalid", 32'(rvalid), 0);
        check("t6_rdata", 32'(rdata), 0);
        rst = 1'b0;
        req = 2'b11; dir_out = 2'b00;
        step();
        check("t6_ptr0_gnt", 32'(gnt), 32'b01);

        // Randomized run on the 3-requester instance against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            b_ena = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < B_N; i++) begin
                if ($urandom_range(0, 3) == 0) b_req[i] = ~b_req[i];
            end
            b_dir    = B_N'($urandom);
            b_wdata  = (8*B_N)'($urandom);
            b_uio_in = 8'($urandom);
            model_edge();
            step();
            check($sformatf("rnd_gnt[%0d]", c), 32'(b_gnt), 32'(m_gnt));
            check($sformatf("rnd_oe[%0d]", c), 32'(b_uio_oe), 32'(m_oe));
            check($sformatf("rnd_out[%0d]", c), 32'(b_uio_out), 32'(m_out));
            check($sformatf("rnd_rv[%0d]", c), 32'(b_rvalid), 32'(m_rvalid));
            check($sformatf("rnd_rdata[%0d]", c), 32'(b_rdata), 32'(m_rdata));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
